// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared core types and the address width macro
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;
    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;
endpackage

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup and execute feedback bundle for the BTB
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface branch_target_buffer_if;
    import mips_core_pkg::*;

    logic                   i_req_valid;
    logic [`ADDR_WIDTH-1:0] i_req_pc;
    logic                   o_hit;
    BranchOutcome           o_prediction;
    logic [`ADDR_WIDTH-1:0] o_target;

    logic                   i_fb_valid;
    logic [`ADDR_WIDTH-1:0] i_fb_pc;
    logic                   i_fb_is_jump;
    BranchOutcome           i_fb_outcome;
    logic [`ADDR_WIDTH-1:0] i_fb_target;

    modport master (
        output i_req_valid, i_req_pc, i_fb_valid, i_fb_pc, i_fb_is_jump, i_fb_outcome, i_fb_target,
        input  o_hit, o_prediction, o_target
    );

    modport slave (
        input  i_req_valid, i_req_pc, i_fb_valid, i_fb_pc, i_fb_is_jump, i_fb_outcome, i_fb_target,
        output o_hit, o_prediction, o_target
    );
endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped fetch BTB with 2-bit counters; BTB_STATS_EN adds lookup/hit counters
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_target_buffer
    import mips_core_pkg::*;
#(
    parameter int ENTRIES    = 64,
    parameter int INDEX_BITS = $clog2(ENTRIES),
    parameter int TAG_BITS   = `ADDR_WIDTH - INDEX_BITS - 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_target_buffer_if.slave     bus,
    output logic [31:0]               o_lookup_count,
    output logic [31:0]               o_hit_count
);
    localparam int AW = `ADDR_WIDTH;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [AW-1:0]       target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req_taken;

    logic [INDEX_BITS-1:0] fb_idx;
    logic [TAG_BITS-1:0]   fb_tag;
    logic                  fb_hit;
    logic                  fb_taken;
    logic                  alloc;
    logic                  ctr_we;
    logic                  target_we;
    logic [1:0]            ctr_d;

    logic unused_pc_low;
    assign unused_pc_low = ^{bus.i_req_pc[1:0], bus.i_fb_pc[1:0]};

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign req_idx   = bus.i_req_pc[INDEX_BITS+1:2];
    assign req_tag   = bus.i_req_pc[AW-1:INDEX_BITS+2];
    assign bus.o_hit = bus.i_req_valid & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign req_taken = bus.o_hit & ctr_q[req_idx][1];
    assign bus.o_prediction = req_taken ? TAKEN : NOT_TAKEN;
    assign bus.o_target     = req_taken ? target_q[req_idx] : bus.i_req_pc + AW'(4);

    assign fb_idx   = bus.i_fb_pc[INDEX_BITS+1:2];
    assign fb_tag   = bus.i_fb_pc[AW-1:INDEX_BITS+2];
    assign fb_hit   = valid_q[fb_idx] & (tag_q[fb_idx] == fb_tag);
    assign fb_taken = (bus.i_fb_outcome == TAKEN);

    always_comb begin
        ctr_d     = ctr_q[fb_idx];
        ctr_we    = 1'b0;
        target_we = 1'b0;
        alloc     = 1'b0;
        if (bus.i_fb_valid) begin
            if (fb_hit) begin
                ctr_we = 1'b1;
                if (bus.i_fb_is_jump) begin
                    ctr_d     = 2'b11;
                    target_we = 1'b1;
                end else if (fb_taken) begin
                    ctr_d     = (ctr_q[fb_idx] == 2'b11) ? 2'b11 : ctr_q[fb_idx] + 2'b01;
                    target_we = 1'b1;
                end else begin
                    ctr_d     = (ctr_q[fb_idx] == 2'b00) ? 2'b00 : ctr_q[fb_idx] - 2'b01;
                end
            end else if (bus.i_fb_is_jump || fb_taken) begin
                alloc     = 1'b1;
                ctr_we    = 1'b1;
                target_we = 1'b1;
                ctr_d     = bus.i_fb_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[fb_idx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; writes are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (alloc)     tag_q[fb_idx]    <= fb_tag;
            if (ctr_we)    ctr_q[fb_idx]    <= ctr_d;
            if (target_we) target_q[fb_idx] <= bus.i_fb_target;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookup_count_q;
    logic [31:0] hit_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_count_q <= '0;
            hit_count_q    <= '0;
        end else begin
            if (bus.i_req_valid && lookup_count_q != 32'hFFFF_FFFF)
                lookup_count_q <= lookup_count_q + 32'd1;
            if (bus.o_hit && hit_count_q != 32'hFFFF_FFFF)
                hit_count_q <= hit_count_q + 32'd1;
        end
    end

    assign o_lookup_count = lookup_count_q;
    assign o_hit_count    = hit_count_q;
`else
    assign o_lookup_count = 32'd0;
    assign o_hit_count    = 32'd0;
`endif
endmodule
